// File: rtl/rfphoenix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rfPhoenixPkg
// Description : Shared decode / fetch bus types for the rfPhoenix pipeline.
// Revision    : 1.0  initial issue-stage support
// ============================================================================
package rfPhoenixPkg;

    localparam int NREGS_DEFAULT = 64;

    typedef logic [5:0] RegIdx;

    typedef struct packed {
        logic [6:0]  opcode;
        RegIdx       Ra;
        RegIdx       Rb;
        RegIdx       Rc;
        RegIdx       Rt;
        logic        rfwr;
        logic        sync;
        logic [15:0] imm;
    } DecodeBus;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } InstructionFetchbuf;

endpackage
`default_nettype wire

// File: rtl/rfphoenix_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rfphoenix_scoreboard
// Description : Register-busy vector with set/clear ports and hazard compare.
// Revision    : 1.0  initial
// ============================================================================
module rfphoenix_scoreboard #(
    parameter int NREGS = 64,
    localparam int IW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_v,
    input  logic [IW-1:0]    clr_idx,
    input  logic             set_v,
    input  logic [IW-1:0]    set_idx,
    input  logic [IW-1:0]    ra,
    input  logic [IW-1:0]    rb,
    input  logic [IW-1:0]    rc,
    input  logic [IW-1:0]    rt,
    input  logic             rfwr,
    input  logic             sync,
    output logic [NREGS-1:0] busy,
    output logic             hazard
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             w_src_haz;
    logic             w_waw_haz;
    logic             w_sync_haz;

    // Set is applied after clear so a same-cycle set on the cleared register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_v) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (set_v) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign w_src_haz  = busy_q[ra] | busy_q[rb] | busy_q[rc];
    assign w_waw_haz  = rfwr & busy_q[rt];
    assign w_sync_haz = sync & (|busy_q);
    assign hazard     = w_src_haz | w_waw_haz | w_sync_haz;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: rtl/rfphoenix_issue.sv
`default_nettype none
// ============================================================================
// Module      : rfphoenix_issue
// Description : In-order issue stage: scoreboard hazard check, single output
//               register with valid/ready handshake, stall counter.
// Revision    : 1.0  initial
// ============================================================================
module rfphoenix_issue
    import rfPhoenixPkg::*;
#(
    parameter int NREGS = rfPhoenixPkg::NREGS_DEFAULT,
    localparam int IW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                q_v,
    input  DecodeBus            q_dec,
    input  InstructionFetchbuf  q_ifb,
    output logic                q_rd,
    output logic                ex_v,
    output DecodeBus            ex_dec,
    output InstructionFetchbuf  ex_ifb,
    input  logic                ex_rdy,
    input  logic                wb_v,
    input  logic [IW-1:0]       wb_tgt,
    input  logic                flush,
    output logic [NREGS-1:0]    sb_busy,
    output logic [31:0]         stall_cnt
);

    localparam logic [31:0] c_STALL_MAX = 32'hFFFF_FFFF;

    logic                w_hazard;
    logic                w_fire;
    logic                w_set_v;
    logic                ex_v_q;
    logic                ex_v_d;
    DecodeBus            ex_dec_q;
    DecodeBus            ex_dec_d;
    InstructionFetchbuf  ex_ifb_q;
    InstructionFetchbuf  ex_ifb_d;
    logic [31:0]         stall_cnt_q;
    logic [31:0]         stall_cnt_d;

    rfphoenix_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .clr_v   (wb_v),
        .clr_idx (wb_tgt),
        .set_v   (w_set_v),
        .set_idx (IW'(q_dec.Rt)),
        .ra      (IW'(q_dec.Ra)),
        .rb      (IW'(q_dec.Rb)),
        .rc      (IW'(q_dec.Rc)),
        .rt      (IW'(q_dec.Rt)),
        .rfwr    (q_dec.rfwr),
        .sync    (q_dec.sync),
        .busy    (sb_busy),
        .hazard  (w_hazard)
    );

    // Gated by rst so the FIFO never sees a pop while both sides are in reset.
    assign w_fire  = q_v & ~w_hazard & (~ex_v_q | ex_rdy) & ~flush & ~rst;
    assign w_set_v = w_fire & q_dec.rfwr & (q_dec.Rt != '0);
    assign q_rd    = w_fire;

    always_comb begin
        ex_v_d   = ex_v_q;
        ex_dec_d = ex_dec_q;
        ex_ifb_d = ex_ifb_q;
        if (flush) begin
            ex_v_d = 1'b0;
        end else if (w_fire) begin
            ex_v_d   = 1'b1;
            ex_dec_d = q_dec;
            ex_ifb_d = q_ifb;
        end else if (ex_rdy) begin
            ex_v_d = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (q_v & w_hazard & (stall_cnt_q != c_STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_v_q      <= 1'b0;
            ex_dec_q    <= '0;
            ex_ifb_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_v_q      <= ex_v_d;
            ex_dec_q    <= ex_dec_d;
            ex_ifb_q    <= ex_ifb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_v      = ex_v_q;
    assign ex_dec    = ex_dec_q;
    assign ex_ifb    = ex_ifb_q;
    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rfphoenix_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_rfphoenix_issue
// Description : Self-checking bench for rfphoenix_issue with a FIFO model,
//               behavioural reference and directed plus random stimulus.
// Revision    : 1.0  initial
// ============================================================================
module tb_rfphoenix_issue;
    import rfPhoenixPkg::*;

    localparam int NR = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               q_v;
    DecodeBus           q_dec;
    InstructionFetchbuf q_ifb;
    logic               q_rd;
    logic               ex_v;
    DecodeBus           ex_dec;
    InstructionFetchbuf ex_ifb;
    logic               ex_rdy;
    logic               wb_v;
    logic [5:0]         wb_tgt;
    logic               flush;
    logic [NR-1:0]      sb_busy;
    logic [31:0]        stall_cnt;

    rfphoenix_issue #(.NREGS(NR)) dut (
        .clk(clk), .rst(rst), .q_v(q_v), .q_dec(q_dec), .q_ifb(q_ifb),
        .q_rd(q_rd), .ex_v(ex_v), .ex_dec(ex_dec), .ex_ifb(ex_ifb),
        .ex_rdy(ex_rdy), .wb_v(wb_v), .wb_tgt(wb_tgt), .flush(flush),
        .sb_busy(sb_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        DecodeBus           d;
        InstructionFetchbuf f;
    } op_t;

    op_t  fifo[$];
    int   checks = 0;
    int   errors = 0;
    logic last_qrd = 1'b0;
    int   n_qrd = 0;
    int   n_exv = 0;

    bit                 m_busy[NR];
    logic               m_exv;
    DecodeBus           m_dec;
    InstructionFetchbuf m_ifb;
    logic [31:0]        m_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an instruction is blocked if any register it touches is pending.
    function automatic logic m_haz();
        if (m_busy[q_dec.Ra] || m_busy[q_dec.Rb] || m_busy[q_dec.Rc]) return 1'b1;
        if (q_dec.rfwr && m_busy[q_dec.Rt]) return 1'b1;
        if (q_dec.sync) begin
            for (int i = 0; i < NR; i++) if (m_busy[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic m_fire();
        return !rst && q_v && !m_haz() && (!m_exv || ex_rdy) && !flush;
    endfunction

    function automatic logic [63:0] m_busy_vec();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i] = m_busy[i];
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) m_busy[i] <= 1'b0;
            m_exv   <= 1'b0;
            m_dec   <= '0;
            m_ifb   <= '0;
            m_stall <= '0;
        end else begin
            if (q_v && m_haz() && m_stall != 32'hFFFF_FFFF) m_stall <= m_stall + 32'd1;
            if (wb_v) m_busy[wb_tgt] <= 1'b0;
            if (m_fire() && q_dec.rfwr && q_dec.Rt != 6'd0) m_busy[q_dec.Rt] <= 1'b1;
            if (flush) m_exv <= 1'b0;
            else if (m_fire()) begin
                m_exv <= 1'b1;
                m_dec <= q_dec;
                m_ifb <= q_ifb;
            end else if (ex_rdy) m_exv <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("q_rd", 64'(q_rd), 64'(m_fire()));
        chk("ex_v", 64'(ex_v), 64'(m_exv));
        if (m_exv) begin
            chk("ex_dec", 64'(ex_dec), 64'(m_dec));
            chk("ex_ifb", 64'(ex_ifb), 64'(m_ifb));
        end
        chk("sb_busy", sb_busy, m_busy_vec());
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        last_qrd = q_rd;
        if (q_rd) n_qrd++;
        if (ex_v) n_exv++;
    end

    task automatic drive_head();
        q_v = (fifo.size() > 0);
        if (fifo.size() > 0) begin
            q_dec = fifo[0].d;
            q_ifb = fifo[0].f;
        end else begin
            q_dec = '0;
            q_ifb = '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (last_qrd && fifo.size() > 0) fifo.delete(0);
        #1;
        drive_head();
    endtask

    task automatic push(input op_t o);
        fifo.push_back(o);
        drive_head();
    endtask

    task automatic wb(input int r);
        wb_v   = 1'b1;
        wb_tgt = 6'(r);
        step();
        wb_v   = 1'b0;
    endtask

    function automatic op_t mk(input int ra, input int rb, input int rc, input int rt,
                               input logic rfwr, input logic sync);
        op_t o;
        o.d.opcode = 7'($urandom);
        o.d.Ra     = RegIdx'(ra);
        o.d.Rb     = RegIdx'(rb);
        o.d.Rc     = RegIdx'(rc);
        o.d.Rt     = RegIdx'(rt);
        o.d.rfwr   = rfwr;
        o.d.sync   = sync;
        o.d.imm    = 16'($urandom);
        o.f.pc     = $urandom;
        o.f.insn   = $urandom;
        return o;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ex_v"}, 64'(ex_v), 64'd0);
        chk({tag, "_ex_dec"}, 64'(ex_dec), 64'd0);
        chk({tag, "_ex_ifb"}, 64'(ex_ifb), 64'd0);
        chk({tag, "_sb_busy"}, sb_busy, 64'd0);
        chk({tag, "_stall"}, 64'(stall_cnt), 64'd0);
        chk({tag, "_q_rd"}, 64'(q_rd), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        op_t a, b, p1, p2, sy, z;
        logic [31:0] s0;
        q_v = 1'b0; q_dec = '0; q_ifb = '0; ex_rdy = 1'b1;
        wb_v = 1'b0; wb_tgt = '0; flush = 1'b0; rst = 1'b1;
        #2;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Independent stream of four writers.
        n_qrd = 0; n_exv = 0;
        for (int r = 1; r <= 4; r++) push(mk(0, 0, 0, r, 1'b1, 1'b0));
        repeat (6) step();
        chk("indep_qrd_cycles", 64'(n_qrd), 64'd4);
        chk("indep_exv_cycles", 64'(n_exv), 64'd4);
        chk("indep_sb_busy", sb_busy, 64'h1E);
        chk("indep_stall", 64'(stall_cnt), 64'd0);
        for (int r = 1; r <= 4; r++) wb(r);
        #1 chk("indep_cleared", sb_busy, 64'd0);

        // RAW stall released by writeback.
        a = mk(0, 0, 0, 5, 1'b1, 1'b0);
        b = mk(5, 0, 0, 0, 1'b0, 1'b0);
        push(a); push(b);
        step();
        s0 = stall_cnt;
        for (int k = 1; k <= 3; k++) begin
            step();
            #1;
            chk("raw_stall_inc", 64'(stall_cnt), 64'(s0 + 32'(k)));
            chk("raw_held", 64'(q_rd), 64'd0);
        end
        wb_v = 1'b1; wb_tgt = 6'd5;
        #1 chk("raw_no_bypass", 64'(q_rd), 64'd0);
        step();
        wb_v = 1'b0;
        #1 chk("raw_fire_n1", 64'(q_rd), 64'd1);
        step();
        #1;
        chk("raw_exv_n2", 64'(ex_v), 64'd1);
        chk("raw_exdec_n2", 64'(ex_dec), 64'(b.d));

        // Same-cycle clear and set of r7: set wins.
        push(mk(0, 0, 0, 7, 1'b1, 1'b0));
        wb_v = 1'b1; wb_tgt = 6'd7;
        #1 chk("sbc_fire", 64'(q_rd), 64'd1);
        step();
        wb_v = 1'b0;
        #1 chk("sbc_busy7", 64'(sb_busy[7]), 64'd1);
        wb(7);

        // Backpressure holds the output register.
        p1 = mk(0, 0, 0, 0, 1'b0, 1'b0);
        p2 = mk(0, 0, 0, 0, 1'b0, 1'b0);
        ex_rdy = 1'b0;
        push(p1); push(p2);
        step();
        s0 = stall_cnt;
        repeat (3) begin
            #1;
            chk("bp_qrd", 64'(q_rd), 64'd0);
            chk("bp_exdec", 64'(ex_dec), 64'(p1.d));
            chk("bp_exv", 64'(ex_v), 64'd1);
            step();
        end
        chk("bp_stall_same", 64'(stall_cnt), 64'(s0));
        ex_rdy = 1'b1;
        #1 chk("bp_release_fire", 64'(q_rd), 64'd1);
        step();
        #1 chk("bp_next_op", 64'(ex_dec), 64'(p2.d));

        // Serialising op waits for an empty scoreboard; then flush.
        push(mk(0, 0, 0, 5, 1'b1, 1'b0));
        step();
        sy = mk(0, 0, 0, 6, 1'b1, 1'b1);
        push(sy);
        #1;
        chk("sync_busy20", sb_busy, 64'h20);
        chk("sync_blocked", 64'(q_rd), 64'd0);
        repeat (2) step();
        #1 chk("sync_still_blocked", 64'(q_rd), 64'd0);
        wb_v = 1'b1; wb_tgt = 6'd5;
        step();
        wb_v = 1'b0;
        #1 chk("sync_fire", 64'(q_rd), 64'd1);
        step();
        #1;
        chk("sync_issued", 64'(ex_dec), 64'(sy.d));
        chk("sync_busy40", sb_busy, 64'h40);
        ex_rdy = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("flush_exv", 64'(ex_v), 64'd0);
        chk("flush_sb_kept", sb_busy, 64'h40);
        ex_rdy = 1'b1;
        wb(6);

        // Mid-run asynchronous reset, then build sb_busy=0x3C with 9 stalls.
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        fifo.delete();
        drive_head();
        for (int r = 2; r <= 5; r++) push(mk(0, 0, 0, r, 1'b1, 1'b0));
        z = mk(2, 0, 0, 0, 1'b0, 1'b0);
        push(z);
        for (int k = 0; k < 40 && stall_cnt != 32'd9; k++) step();
        chk("pre_rst_stall", 64'(stall_cnt), 64'd9);
        chk("pre_rst_busy", sb_busy, 64'h3C);
        #1 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        fifo.delete();
        drive_head();
        step();
        rst = 1'b0;

        // Randomised traffic checked cycle by cycle against the model.
        for (int c = 0; c < 2000; c++) begin
            if (fifo.size() < 3 && $urandom_range(0, 1) == 1)
                push(mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 15) == 0)));
            ex_rdy = ($urandom_range(0, 3) != 0);
            wb_v   = ($urandom_range(0, 2) == 0);
            wb_tgt = 6'($urandom_range(0, 7));
            flush  = ($urandom_range(0, 31) == 0);
            step();
        end
        wb_v = 1'b0; flush = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
